// File: rtl/io_input_ctrl.sv
// Prefetching byte-input controller: single-outstanding source reads into a FIFO,
// round-robin grants to loader (0) and CPU (1). Optional macro: IO_IN_EOF_MARK_EN.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module io_input_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  areset,
  output logic                  src_read,
  input  logic [7:0]            src_data,
  input  logic                  src_eof,
  input  logic                  req0,
  input  logic                  req1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [`WORD_SIZE-1:0] out_data,
  output logic                  out_eof
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {FILL = 2'd0, CAPTURE = 2'd1, DONE = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic                    src_read_q, src_read_d;
  logic [7:0]              mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    eof_seen_q, eof_seen_d;
  logic                    last_q, last_d;
  logic                    ack0_q, ack1_q;
  logic [`WORD_SIZE-1:0]   out_data_q, out_data_d;
  logic                    out_eof_q, out_eof_d;

  logic                    push_s, pop_s, elig_s, gnt0_s, gnt1_s;
  logic [`WORD_SIZE-1:0]   word_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!areset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave FILL only once a read pulse has actually been issued
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (src_read_q) state_d = CAPTURE; else state_d = FILL;
      CAPTURE: if (src_eof) state_d = DONE; else state_d = FILL;
      DONE:    state_d = DONE;
      default: state_d = FILL;
    endcase
  end

  // FSM output: read is issued one cycle ahead so src_read itself is a flop
  always_comb begin
    if ((state_d == FILL) && (count_d < CNT_W'(DEPTH))) begin
      src_read_d = 1'b1;
    end else begin
      src_read_d = 1'b0;
    end
  end

  // FIFO bookkeeping, arbitration and output word selection
  always_comb begin
    push_s = (state_q == CAPTURE) && !src_eof;
`ifdef IO_IN_EOF_MARK_EN
    elig_s = (count_q != '0) || out_eof_q;
`else
    elig_s = (count_q != '0);
`endif
    gnt0_s = req0 && elig_s && (!req1 || last_q);
    gnt1_s = req1 && elig_s && (!req0 || !last_q);
    pop_s  = (gnt0_s || gnt1_s) && (count_q != '0);

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    wr_ptr_d   = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d   = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    eof_seen_d = eof_seen_q || ((state_q == CAPTURE) && src_eof);

    if (gnt0_s) begin
      last_d = 1'b0;
    end else if (gnt1_s) begin
      last_d = 1'b1;
    end else begin
      last_d = last_q;
    end

`ifdef IO_IN_EOF_MARK_EN
    word_s = (count_q == '0) ? {`WORD_SIZE{1'b1}} : `WORD_SIZE'(mem_q[rd_ptr_q]);
`else
    word_s = `WORD_SIZE'(mem_q[rd_ptr_q]);
`endif
    out_data_d = (gnt0_s || gnt1_s) ? word_s : out_data_q;
    out_eof_d  = eof_seen_d && (count_d == '0);
  end

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= src_data;
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (!areset) begin
      src_read_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      eof_seen_q <= 1'b0;
      last_q     <= 1'b1;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      out_data_q <= '0;
      out_eof_q  <= 1'b0;
    end else begin
      src_read_q <= src_read_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      eof_seen_q <= eof_seen_d;
      last_q     <= last_d;
      ack0_q     <= gnt0_s;
      ack1_q     <= gnt1_s;
      out_data_q <= out_data_d;
      out_eof_q  <= out_eof_d;
    end
  end

  assign src_read = src_read_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign out_data = out_data_q;
  assign out_eof  = out_eof_q;

endmodule

// File: tb/tb_io_input_ctrl.sv
// Directed self-checking bench for io_input_ctrl (DEPTH=4); honours IO_IN_EOF_MARK_EN.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module tb_io_input_ctrl;

  logic                  clk = 1'b0;
  logic                  areset = 1'b0;
  logic                  src_read;
  logic [7:0]            src_data = 8'h00;
  logic                  src_eof = 1'b0;
  logic                  req0 = 1'b0;
  logic                  req1 = 1'b0;
  logic                  ack0, ack1;
  logic [`WORD_SIZE-1:0] out_data;
  logic                  out_eof;

  int checks = 0;
  int errors = 0;

  logic [7:0] src_mem [64];
  int         src_pos = 0;
  int         eof_at  = 1000;

  io_input_ctrl #(.DEPTH(4)) dut (
    .clk(clk), .areset(areset), .src_read(src_read), .src_data(src_data),
    .src_eof(src_eof), .req0(req0), .req1(req1), .ack0(ack0), .ack1(ack1),
    .out_data(out_data), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  // Byte source: advances on every read pulse, data valid until the next read
  initial begin
    for (int i = 0; i < 64; i++) src_mem[i] = 8'h41 + 8'(i);
    forever begin
      @(negedge clk);
      if (src_read) begin
        src_data = src_mem[src_pos];
        src_eof  = (src_pos == eof_at);
        src_pos++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_src_read", src_read, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_eof", out_eof, 0);
    chk("rst_count", dut.count_q, 0);
    areset = 1'b1;

    // Prefetch: reads every 2 cycles until four bytes are buffered
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("fill_read_%0d", i), src_read, (i <= 6) && (i % 2 == 0));
    end
    chk("fill_count_full", dut.count_q, 4);

    // Single-cycle CPU requests: in-order data, read resumes after first pop
    req1 = 1'b1;
    @(negedge clk);
    chk("cpu_ack1_a", ack1, 1);
    chk("cpu_ack0_a", ack0, 0);
    chk("cpu_data_a", out_data, 16'h0041);
    chk("cpu_resume_read", src_read, 1);
    req1 = 1'b0;
    @(negedge clk);
    chk("cpu_ack1_idle", ack1, 0);
    chk("cpu_data_hold", out_data, 16'h0041);
    req1 = 1'b1;
    @(negedge clk);
    chk("cpu_ack1_b", ack1, 1);
    chk("cpu_data_b", out_data, 16'h0042);
    chk("cpu_pushpop_count", dut.count_q, 3);
    req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("cpu_refull_count", dut.count_q, 4);
    chk("cpu_refull_noread", src_read, 0);

    // Both requesters continuously: alternate starting with loader, FIFO wraps
    req0 = 1'b1;
    req1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("rr_ack0_%0d", k), ack0, (k % 2 == 0));
      chk($sformatf("rr_ack1_%0d", k), ack1, (k % 2 == 1));
      chk($sformatf("rr_data_%0d", k), out_data, 64'h43 + 64'(k));
      if (k == 2) chk("rr_pushpop_count2", dut.count_q, 2);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    chk("rr_empty_noack", ack0 | ack1, 0);

    // Reset during CAPTURE with two bytes queued
    found = 1'b0;
    for (int w = 0; w < 40 && !found; w++) begin
      if (dut.count_q == 2 && src_read) found = 1'b1;
      else @(negedge clk);
    end
    chk("wait_two_queued", found, 1);
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    chk("mid_rst_src_read", src_read, 0);
    chk("mid_rst_acks", {ack0, ack1}, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_eof", out_eof, 0);
    chk("mid_rst_count", dut.count_q, 0);
    chk("mid_rst_eof_seen", dut.eof_seen_q, 0);
    areset = 1'b1;
    @(negedge clk);
    chk("post_rst_read", src_read, 1);
    @(negedge clk);
    @(negedge clk);
    req0 = 1'b1;
    @(negedge clk);
    chk("post_rst_ack0", ack0, 1);
    chk("post_rst_data", out_data, 16'h004C);
    req0 = 1'b0;

    // EOF after a single 0x0A byte
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    src_mem[src_pos] = 8'h0A;
    eof_at = src_pos + 1;
    @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    chk("eof_read0", src_read, 1);
    @(negedge clk);
    @(negedge clk);
    chk("eof_read1", src_read, 1);
    @(negedge clk);
    @(negedge clk);
    chk("eof_pending_out_eof", out_eof, 0);
    chk("eof_pending_count", dut.count_q, 1);
    chk("eof_done_noread", src_read, 0);
    req0 = 1'b1;
    @(negedge clk);
    chk("eof_last_ack0", ack0, 1);
    chk("eof_last_data", out_data, 16'h000A);
    chk("eof_out_eof", out_eof, 1);
`ifdef IO_IN_EOF_MARK_EN
    for (int m = 0; m < 3; m++) begin
      @(negedge clk);
      chk($sformatf("mark_ack0_%0d", m), ack0, 1);
      chk($sformatf("mark_data_%0d", m), out_data, {`WORD_SIZE{1'b1}});
      chk($sformatf("mark_out_eof_%0d", m), out_eof, 1);
    end
`else
    for (int m = 0; m < 20; m++) begin
      @(negedge clk);
      chk($sformatf("stall_ack0_%0d", m), ack0, 0);
      chk($sformatf("stall_read_%0d", m), src_read, 0);
    end
    chk("stall_out_eof", out_eof, 1);
    chk("stall_data_hold", out_data, 16'h000A);
`endif
    req0 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_input_ctrl.md
# io_input_ctrl

Prefetching controller and two-requester arbiter for the byte-stream input source. It issues single-cycle read pulses to the input source and buffers the returned bytes in a small FIFO. It tracks end-of-file and hands bytes, zero-extended to a machine word, to two requesters. Requester 0 is the boot loader; requester 1 is the CPU IO-read path. The block sits between the input source and the CPU/loader.

## Interface

- DEPTH, 4, FIFO entries; power of two, ≥ 2
- clk  in  1  clock; all logic on posedge
- areset  in  1  synchronous, active-low reset
- src_read  out  1  one-cycle pulse: source fetches next byte
- src_data  in  8  source byte; valid the cycle after src_read
- src_eof  in  1  source EOF flag; valid the cycle after src_read
- req0  in  1  level request, requester 0 (loader)
- req1  in  1  level request, requester 1 (CPU)
- ack0  out  1  one-cycle grant to requester 0; out_data valid this cycle
- ack1  out  1  one-cycle grant to requester 1; out_data valid this cycle
- out_data  out  `WORD_SIZE  granted word: {zeros, byte} (EOF marker with the macro)
- out_eof  out  1  eof_seen and FIFO empty

## Operation

- Fetch FSM states:
  - FILL: assert src_read when count + inflight < DEPTH; go to CAPTURE.
  - CAPTURE: sample src_data/src_eof.
    - src_eof=0: push byte; return to FILL.
    - src_eof=1: discard byte; set eof_seen; go to DONE.
  - DONE: no further src_read until reset.
- Exactly one read in flight; src_read is never asserted in two consecutive cycles.
- FIFO:
  - Circular buffer; rd/wr pointers wrap modulo DEPTH.
  - count is clog2(DEPTH)+1 bits.
  - Push and pop in the same cycle is legal; count is unchanged.
  - The credit check prevents a push when full.
- Arbiter:
  - A request is eligible when the FIFO is non-empty.
  - One grant per cycle.
  - Round-robin pointer `last`: when both requests are eligible, grant the requester ≠ last; then last := granted id.
  - Single eligible request: grant it and update last.
- Grant: ack is registered. Requester must drop req in the cycle ack is seen; a req still high the next cycle counts as a new request.
- No bypass: a byte captured this cycle is grantable from the next cycle.
- Reset mid-read: in-flight byte lost (source already advanced); FIFO cleared; eof_seen cleared.

## Timing

- Reset values: src_read=0, ack0=0, ack1=0, out_data=0, out_eof=0, FIFO empty, eof_seen=0, last=1 (requester 0 wins the first tie), FSM=FILL.
- src_read first asserts in the cycle after areset deasserts.
- Byte path: src_read at cycle N → capture at edge ending N+1 → grantable in N+2 → ack/out_data earliest in N+3.
- Request to ack: req sampled high at edge E with FIFO non-empty → ack high with out_data in the cycle after E; pop at that same edge.
- Sustained throughput: one byte per 2 cycles from the source; one grant per cycle from the FIFO.
- out_data holds its last value when no ack is asserted.
- out_eof rises the cycle after the last pop that empties the FIFO once eof_seen=1, or the cycle after the EOF capture if the FIFO is already empty.

## Configuration

- IO_IN_EOF_MARK_EN defined:
  - When out_eof=1, requests are still granted round-robin.
  - out_data is all-ones (-1 in `WORD_SIZE bits); repeatable indefinitely.
  - Grant latency is unchanged.
- IO_IN_EOF_MARK_EN undefined:
  - When out_eof=1, requests are never acked; requesters stall.
  - out_eof remains the only EOF indication.

## Test plan

- Reset, source bytes 0x41,0x42,0x43, no requests → src_read pulses every 2 cycles until count=4 (DEPTH=4); src_read then stays 0.
- FIFO full, req1 held single-cycle per grant → ack1 with out_data 0x41, then 0x42, in order; src_read resumes after the first pop.
- req0 and req1 both high continuously, FIFO full → ack0,ack1,ack0,ack1 alternating; first grant to req0.
- Source EOF after 0x0A → 0x0A delivered, then out_eof=1. With IO_IN_EOF_MARK_EN, the next req0 gets ack0 with out_data=all-ones. Without it, ack0 stays 0 for 20 cycles.
- areset low for one cycle during CAPTURE with 2 bytes queued → all outputs at reset values; count=0; next bytes come from the source's current position.
- Push and pop in the same cycle at count=2 → count stays 2; pointer wrap after 5+ bytes preserves order.
